// File: rtl/upsampler_iq.sv
// rtl/upsampler_iq.sv - multi-channel zero-stuff / sample-and-hold symbol upsampler
module upsampler_iq #(
    parameter int DATA_W   = 4,
    parameter int CHANNELS = 2,
    parameter int RATE_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic [RATE_W-1:0]            rate,
    input  logic                         mode,
    output logic                         out_valid,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         out_first
);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    localparam logic [RATE_W-1:0] RATE_ONE = {{(RATE_W-1){1'b0}}, 1'b1};

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [RATE_W-1:0]             r_phase;
    logic [RATE_W-1:0]             w_phase_nxt;
    logic [RATE_W-1:0]             r_rate;
    logic [CHANNELS*DATA_W-1:0]    r_sample;
    logic                          r_mode;
    logic                          r_alive;
    logic                          w_last;
    logic                          w_accept;
    logic                          w_emit;
    logic [RATE_W-1:0]             w_rate_eff;

    // r_alive keeps in_ready low during reset and for the first cycle after release
    assign w_emit     = (r_state == S_EMIT);
    assign w_last     = w_emit && (r_phase == (r_rate - RATE_ONE));
    assign in_ready   = r_alive && ((r_state == S_IDLE) || w_last);
    assign w_accept   = in_valid && in_ready;
    assign w_rate_eff = (rate == '0) ? RATE_ONE : rate;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_EMIT;
                    w_phase_nxt = '0;
                end
            end
            S_EMIT: begin
                if (w_last) begin
                    w_phase_nxt = '0;
                    w_state_nxt = w_accept ? S_EMIT : S_IDLE;
                end else begin
                    w_phase_nxt = r_phase + RATE_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_rate   <= '0;
            r_mode   <= 1'b0;
            r_sample <= '0;
            r_alive  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_alive <= 1'b1;
            if (w_accept) begin
                r_sample <= in_data;
                r_mode   <= mode;
                r_rate   <= w_rate_eff;
            end
        end
    end

    // Outputs decode registered state only, so the async reset clears them immediately
    assign out_valid = w_emit;
    assign out_first = w_emit && (r_phase == '0);
    assign out_data  = (w_emit && ((r_phase == '0) || r_mode)) ? r_sample : '0;

endmodule

// File: tb/tb_upsampler_iq.sv
// tb/tb_upsampler_iq.sv - scoreboard bench for upsampler_iq
module tb_upsampler_iq;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic        first;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [3:0]  rate = '0;
    logic        mode = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_first;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [31:0] w_in_data = '0;
    logic [4:0]  w_rate = '0;
    logic        w_mode = 1'b0;
    logic        w_out_valid;
    logic [31:0] w_out_data;
    logic        w_out_first;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    bit   mon2_en = 1'b0;
    exp_t q[$];
    exp_t q2[$];

    upsampler_iq #(.DATA_W(4), .CHANNELS(2), .RATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rate(rate), .mode(mode),
        .out_valid(out_valid), .out_data(out_data), .out_first(out_first)
    );

    upsampler_iq #(.DATA_W(8), .CHANNELS(4), .RATE_W(5)) dut_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .rate(w_rate), .mode(w_mode),
        .out_valid(w_out_valid), .out_data(w_out_data), .out_first(w_out_first)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                check("out_valid", 64'(out_valid), 64'd1);
                check("out_data", 64'(out_data), q[0].data);
                check("out_first", 64'(out_first), 64'(q[0].first));
                check("in_ready_emit", 64'(in_ready), 64'(q[0].last));
                void'(q.pop_front());
            end else begin
                check("idle_valid", 64'(out_valid), 64'd0);
                check("idle_data", 64'(out_data), 64'd0);
                check("idle_first", 64'(out_first), 64'd0);
                check("idle_ready", 64'(in_ready), 64'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (mon2_en) begin
            if (q2.size() > 0 && q2[0].cyc == cyc) begin
                check("w_out_valid", 64'(w_out_valid), 64'd1);
                check("w_out_data", 64'(w_out_data), q2[0].data);
                check("w_out_first", 64'(w_out_first), 64'(q2[0].first));
                void'(q2.pop_front());
            end else begin
                check("w_idle_valid", 64'(w_out_valid), 64'd0);
                check("w_idle_data", 64'(w_out_data), 64'd0);
            end
        end
    end

    // Called at a falling edge; leaves in_valid high so callers can chain frames.
    task automatic send(input logic [7:0] d, input logic [3:0] r, input logic m);
        int   reff;
        int   waited;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        rate     = r;
        mode     = m;
        waited   = 0;
        #1;
        while (!in_ready && waited < 64) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            reff = (r == 4'd0) ? 1 : int'(r);
            for (int k = 0; k < reff; k++) begin
                e.cyc   = cyc + 1 + k;
                e.data  = (k == 0 || m) ? 64'(d) : 64'd0;
                e.first = (k == 0);
                e.last  = (k == reff - 1);
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        in_valid = 1'b0;
        while ((q.size() > 0 || q2.size() > 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue", 64'(q.size() + q2.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_first", 64'(out_first), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en  = 1'b1;
        mon2_en = 1'b1;
        @(negedge clk);

        // zero-stuff, one frame: I=5 on channel 0, Q=3 on channel 1
        send({4'd3, 4'd5}, 4'd4, 1'b0);
        idle(1);
        drain();

        // hold mode, back-to-back frames
        send({4'd2, 4'd1}, 4'd3, 1'b1);
        send({4'd6, 4'd7}, 4'd3, 1'b1);
        drain();

        // rate 0 and rate 1 passthrough streams
        for (int v = 1; v <= 5; v++) send({4'(v), 4'(v)}, 4'd0, 1'b0);
        for (int v = 1; v <= 5; v++) send({4'(v), 4'(v)}, 4'd1, 1'b1);
        drain();

        // rate/mode changed while a frame runs; the next accept picks them up
        send({4'd9, 4'd4}, 4'd4, 1'b0);
        send({4'd1, 4'd8}, 4'd2, 1'b1);
        drain();

        // reset during phase 1 of a rate-8 frame
        send({4'd2, 4'd9}, 4'd8, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        q.delete();
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_first", 64'(out_first), 64'd0);
        check("async_data", 64'(out_data), 64'd0);
        check("async_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        mon_en = 1'b1;
        idle(10);

        // wide instance: 4 channels of 8 bits, rate 31
        w_in_valid = 1'b1;
        w_rate     = 5'd31;
        w_mode     = 1'b0;
        w_in_data  = 32'hA5A5_A5A5;
        #1;
        check("w_in_ready", 64'(w_in_ready), 64'd1);
        for (int k = 0; k < 31; k++) begin
            e.cyc   = cyc + 1 + k;
            e.data  = (k == 0) ? 64'h0000_0000_A5A5_A5A5 : 64'd0;
            e.first = (k == 0);
            e.last  = (k == 30);
            q2.push_back(e);
        end
        @(negedge clk);
        w_in_valid = 1'b0;
        w_in_data  = '0;
        drain();
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upsampler_iq.md
Name: upsampler_iq

Overview:
- Parametrised multi-channel successor to the single-channel zero-insertion upsampler in the DSP stack.
- Accepts one symbol per frame through a valid/ready handshake and emits RATE output samples per symbol on every channel.
- Two modes: zero-stuff (impulse train for the pulse-shaping FIR) or sample-and-hold.
- Sits between the QAM mapper (I/Q levels) and the pulse-shaping filter.

Parameters:
- DATA_W, 4, bit width of one channel sample.
- CHANNELS, 2, number of parallel channels sharing one phase counter (2 = I/Q).
- RATE_W, 4, width of the rate input; maximum rate is 2^RATE_W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a valid symbol.
- in_ready  output  1  block can accept a symbol this cycle.
- in_data  input  CHANNELS*DATA_W  packed symbol; channel k occupies bits [k*DATA_W +: DATA_W].
- rate  input  RATE_W  upsample factor R; sampled only at accept.
- mode  input  1  0 = zero-stuff, 1 = hold; sampled only at accept.
- out_valid  output  1  out_data is a valid output sample.
- out_data  output  CHANNELS*DATA_W  upsampled samples, same packing as in_data.
- out_first  output  1  high on phase 0 of each frame (symbol strobe).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, phase=0, sample/rate/mode registers=0, out_valid=0, out_first=0, out_data=0. in_ready is 1 one cycle after release.
- Accept = in_valid && in_ready at a rising edge. At accept, latch in_data, mode, and R_eff. R_eff = rate, except R_eff = 1 when rate = 0.
- States:
  - IDLE: in_ready=1. On accept, go to EMIT with phase=0.
  - EMIT: one output per cycle. phase counts 0..R_eff-1.
- Latency: accept at edge N produces phase 0 on the outputs in the cycle after edge N (one register stage).
- Outputs in EMIT: out_valid=1 on every phase.
  - out_first=1 only on phase 0.
  - out_data = latched sample on phase 0.
  - On phases 1..R_eff-1: 0 when mode=0, latched sample when mode=1.
- in_ready in EMIT is 1 only on the last phase (phase == R_eff-1). This gives gap-free back-to-back frames.
- Accept on the last phase: new frame starts at phase 0 on the next cycle, with no idle cycle.
- No accept on the last phase: return to IDLE. out_valid=0 and out_data=0 from the next cycle.
- R_eff=1: every cycle is both phase 0 and the last phase. This is passthrough with 1-cycle latency and out_first=1 on every sample.
- Changes to rate or mode mid-frame have no effect until the next accept.
- There is no output backpressure; the downstream filter always consumes.
- Phase counter is RATE_W bits wide and never wraps past R_eff-1.
- Channels are processed identically and in lockstep; there is no per-channel state.
- Reset asserted mid-frame aborts the frame immediately. All outputs go to their reset values, with no partial-frame completion after release.

Test Plan:
- Reset, then rate=4, mode=0, one accept with I=5, Q=3 -> out_data I/Q sequence (5,3),(0,0),(0,0),(0,0); out_first pattern 1,0,0,0; out_valid high for exactly 4 cycles, then 0.
- rate=3, mode=1, in_valid held high with symbols (1,2),(7,6) -> 6 contiguous valid cycles (1,2)x3 then (7,6)x3; in_ready high only on phase 2 of each frame and in IDLE.
- rate=0, then rate=1, with a stream 1..5 on both channels -> each sample appears 1 cycle after accept; out_first and in_ready constantly 1; no idle gap.
- rate=4 accepted, rate driven to 2 and mode toggled during the frame -> frame still 4 phases in the original mode; the next accept uses rate 2.
- rst_n pulsed low during phase 1 of a rate-8 frame -> out_valid, out_first, and out_data go to 0 asynchronously; after release, no residual samples and in_ready=1.
- DATA_W=8, CHANNELS=4, RATE_W=5, rate=31, mode=0, accept 0xA5 on all channels -> 31-cycle frame with channel words 0xA5 on phase 0, 0 otherwise; correct packing per channel.
